conv_mem_responder: RTL and testbench
=====================================

Name: conv_mem_responder

Overview:
- Memory-side counterpart of the 3x3 convolution engine's host bus.
- Owns the 64x64 input image store, the layer-0 store (4096 words) and the layer-1 store (1024 words).
- Serves the engine's iaddr/idata reads and its cwr/crd/csel accesses.
- Runs the ready/busy start handshake, then streams both result layers out for checking.

Parameters:
- DW, 13, data word width (signed image data, unsigned layer data)
- AW, 12, address width of all stores
- L1_DEPTH, 1024, number of valid layer-1 words
- TIMEOUT, 20000, max cycles from ready to busy falling before err_timeout

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- img_we  in  1  image load write strobe
- img_addr  in  12  image load address
- img_data  in  13  image load data
- start  in  1  pulse: begin a run
- ready  out  1  to engine
- busy  in  1  from engine
- iaddr  in  12  image read address
- idata  out  13  image read data
- cwr  in  1  layer write enable
- caddr_wr  in  12  layer write address
- cdata_wr  in  13  layer write data
- crd  in  1  layer read enable
- caddr_rd  in  12  layer read address
- cdata_rd  out  13  layer read data
- csel  in  1  0 selects layer 0, 1 selects layer 1
- out_valid  out  1  readout word valid
- out_ready  in  1  readout sink ready
- out_sel  out  1  layer of readout word
- out_addr  out  12  address of readout word
- out_data  out  13  readout word
- done  out  1  readout complete, held high
- err_oob  out  1  sticky: layer-1 access with address >= L1_DEPTH
- err_timeout  out  1  sticky: watchdog expired

Behaviour:
Reset (reset==0 at posedge):
- state=IDLE; ready=0, out_valid=0, out_sel=0, out_addr=0, out_data=0, done=0, err_oob=0, err_timeout=0.
- Store contents are retained.

Image reads:
- idata is a combinational read of image[iaddr]; valid in the same cycle. The engine samples it one edge after driving iaddr.

Layer reads:
- cdata_rd is combinational: crd ? (csel ? L1[caddr_rd] : L0[caddr_rd]) : 0.
- csel=1 with caddr_rd >= L1_DEPTH returns 0 and sets err_oob.

Layer writes:
- At a posedge with cwr=1, bank[csel][caddr_wr] <= cdata_wr.
- csel=1 with caddr_wr >= L1_DEPTH: write dropped, err_oob set.
- Write and read to the same address in the same cycle: cdata_rd shows the old value in that cycle and the new value after the edge.
- Image, L0 and L1 writes are accepted in every state; image loads are intended for IDLE only.

State machine:
- IDLE: start -> ARM.
- ARM: ready=1 and the watchdog counts. Sampling busy=1 -> RUN, with ready=0 on the same edge.
- RUN: ready=0. Sampling busy=0 -> DUMP.
- DUMP: out_valid=1.
  - Words are presented as L0 addresses 0..4095 (out_sel=0), then L1 addresses 0..1023 (out_sel=1).
  - out_data is the registered store word at the presented address.
  - Each out_valid&&out_ready edge advances to the next word. While out_ready=0, outputs hold stable.
  - The transfer of L1[1023] -> FIN.
- FIN: out_valid=0, done=1. start -> ARM with done cleared; the image store is unchanged.

Watchdog:
- Counts cycles in ARM and RUN; cleared on entering ARM.
- On reaching TIMEOUT: err_timeout=1, ready=0, go to FIN with done=1.

Other boundaries:
- start outside IDLE/FIN is ignored.
- reset mid-run forces IDLE immediately; any engine writes that follow still land in the stores.

Test Plan:
- Load image[i]=i[12:0]; drive iaddr=0, 63, 4095 -> idata=0, 63, 4095 in the same cycle.
- Pulse start -> ready=1 the next cycle. Raise busy two cycles later -> ready=0 on that edge, state RUN.
- In RUN, cwr=1, csel=0, caddr_wr=5, cdata_wr=13'h0123; next cycle crd=1, caddr_rd=5 -> cdata_rd=13'h0123. The same access with csel=1 reads L1[5], not L0.
- csel=1, caddr_wr=1024, cwr=1 -> L1 unchanged, err_oob=1 and it stays high until reset.
- Drop busy -> DUMP. With out_ready toggling 1,0,1, word L0[0] holds while out_ready=0. Exactly 5120 transfers occur, the last being out_sel=1, out_addr=1023, then done=1.
- Set TIMEOUT=100 and never raise busy -> err_timeout=1 and ready=0 after 100 cycles. Assert reset=0 mid-DUMP -> all outputs at reset values the next cycle, and L0 contents still read back correctly.

Source files
------------

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the 3x3 convolution engine: image/L0/L1 stores,
// ready/busy start handshake with watchdog, and a flow-controlled readout of both layers.
module conv_mem_responder #(
  parameter int DW       = 13,
  parameter int AW       = 12,
  parameter int L1_DEPTH = 1024,
  parameter int TIMEOUT  = 20000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          img_we,
  input  logic [AW-1:0] img_addr,
  input  logic [DW-1:0] img_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          csel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sel,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          done,
  output logic          err_oob,
  output logic          err_timeout
);
  localparam int L0_DEPTH = 1 << AW;
  localparam int L1W      = $clog2(L1_DEPTH);
  localparam int WDW      = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]  L0_LAST = AW'(L0_DEPTH - 1);
  localparam logic [AW-1:0]  L1_LAST = AW'(L1_DEPTH - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARM, RUN, DUMP, FIN} state_e;

  logic [DW-1:0] img_mem [L0_DEPTH];
  logic [DW-1:0] l0_mem  [L0_DEPTH];
  logic [DW-1:0] l1_mem  [L1_DEPTH];

  state_e         state_q;
  logic           ready_q, out_valid_q, out_sel_q, done_q, err_oob_q, err_timeout_q;
  logic [AW-1:0]  out_addr_q, out_addr_d;
  logic [DW-1:0]  out_data_q;
  logic [WDW-1:0] wd_q;
  logic           wr_oob, rd_oob;

  assign wr_oob     = cwr && csel && (caddr_wr > L1_LAST);
  assign rd_oob     = crd && csel && (caddr_rd > L1_LAST);
  assign out_addr_d = out_addr_q + 1'b1;

  // Stores have no reset and accept writes in every state, including during reset.
  always_ff @(posedge clk) begin
    if (img_we) img_mem[img_addr] <= img_data;
    if (cwr && !csel) l0_mem[caddr_wr] <= cdata_wr;
    if (cwr && csel && !wr_oob) l1_mem[caddr_wr[L1W-1:0]] <= cdata_wr;
  end

  assign idata = img_mem[iaddr];

  always_comb begin
    cdata_rd = '0;
    if (crd) begin
      if (!csel) cdata_rd = l0_mem[caddr_rd];
      else if (!rd_oob) cdata_rd = l1_mem[caddr_rd[L1W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sel_q     <= 1'b0;
      out_addr_q    <= '0;
      out_data_q    <= '0;
      done_q        <= 1'b0;
      err_oob_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      if (wr_oob || rd_oob) err_oob_q <= 1'b1;
      case (state_q)
        IDLE, FIN: if (start) begin
          state_q <= ARM;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          wd_q    <= '0;
        end
        ARM, RUN: begin
          // Watchdog expiry takes priority over any busy edge in the same cycle.
          if (wd_q == WD_LAST) begin
            err_timeout_q <= 1'b1;
            ready_q       <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= FIN;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (state_q == ARM && busy) begin
              state_q <= RUN;
              ready_q <= 1'b0;
            end else if (state_q == RUN && !busy) begin
              state_q     <= DUMP;
              out_valid_q <= 1'b1;
              out_sel_q   <= 1'b0;
              out_addr_q  <= '0;
              out_data_q  <= l0_mem[0];
            end
          end
        end
        DUMP: if (out_ready) begin
          if (out_sel_q && out_addr_q == L1_LAST) begin
            state_q     <= FIN;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else if (!out_sel_q && out_addr_q == L0_LAST) begin
            out_sel_q  <= 1'b1;
            out_addr_q <= '0;
            out_data_q <= l1_mem[0];
          end else begin
            out_addr_q <= out_addr_d;
            out_data_q <= out_sel_q ? l1_mem[out_addr_d[L1W-1:0]] : l0_mem[out_addr_d];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready       = ready_q;
  assign out_valid   = out_valid_q;
  assign out_sel     = out_sel_q;
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;
  assign done        = done_q;
  assign err_oob     = err_oob_q;
  assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized bench for conv_mem_responder against array models of the three stores
// and the readout order L0[0..4095] then L1[0..1023].
module tb_conv_mem_responder;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset, img_we, start, busy, cwr, crd, csel, out_ready;
  logic [11:0] img_addr, iaddr, caddr_wr, caddr_rd;
  logic [12:0] img_data, cdata_wr;
  logic ready, out_valid, out_sel, done, err_oob, err_timeout;
  logic [12:0] idata, cdata_rd, out_data;
  logic [11:0] out_addr;

  int total = 0, bad = 0;
  logic [12:0] img_m [4096];
  logic [12:0] l0_m  [4096];
  logic [12:0] l1_m  [1024];

  always #5 clk = ~clk;

  conv_mem_responder #(.DW(13), .AW(12), .L1_DEPTH(1024), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .start(start), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .csel(csel), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_addr(out_addr), .out_data(out_data), .done(done),
    .err_oob(err_oob), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_ovalid"}, out_valid, 0);
    chk({tag, "_osel"}, out_sel, 0);
    chk({tag, "_oaddr"}, out_addr, 0);
    chk({tag, "_odata"}, out_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_oob"}, err_oob, 0);
    chk({tag, "_tmo"}, err_timeout, 0);
  endtask

  initial begin
    int k, cyc, a, w, r;
    logic sel_e;
    reset = 0; img_we = 0; start = 0; busy = 0; cwr = 0; crd = 0; csel = 0; out_ready = 0;
    img_addr = 0; iaddr = 0; caddr_wr = 0; caddr_rd = 0; img_data = 0; cdata_wr = 0;
    tick; tick;
    chk_reset_outs("rst");
    reset = 1;

    // Preload image with its own index and both layers with random words.
    for (int i = 0; i < 4096; i++) begin
      img_we = 1; img_addr = i[11:0]; img_data = i[12:0]; img_m[i] = i[12:0];
      cwr = 1; csel = 0; caddr_wr = i[11:0]; cdata_wr = 13'($urandom); l0_m[i] = cdata_wr;
      tick;
    end
    img_we = 0;
    for (int i = 0; i < 1024; i++) begin
      csel = 1; caddr_wr = i[11:0]; cdata_wr = 13'($urandom); l1_m[i] = cdata_wr;
      tick;
    end
    cwr = 0; csel = 0;

    iaddr = 0;    #1 chk("idata_0", idata, 0);
    iaddr = 63;   #1 chk("idata_63", idata, 63);
    iaddr = 4095; #1 chk("idata_4095", idata, 4095);
    for (int j = 0; j < 16; j++) begin
      a = $urandom % 4096;
      img_we = 1; img_addr = a[11:0]; img_data = 13'($urandom); img_m[a] = img_data;
      tick;
    end
    img_we = 0;
    for (int j = 0; j < 16; j++) begin
      a = $urandom % 4096;
      iaddr = a[11:0]; #1 chk("idata_rnd", idata, img_m[a]);
    end
    chk("idle_done", done, 0);
    chk("idle_ready", ready, 0);

    // Handshake: start -> ARM, busy -> RUN.
    start = 1; tick; start = 0;
    chk("arm_ready", ready, 1);
    tick; tick;
    chk("arm_ready_hold", ready, 1);
    busy = 1; tick;
    chk("run_ready", ready, 0);
    chk("run_ovalid", out_valid, 0);

    cwr = 1; csel = 0; caddr_wr = 5; cdata_wr = 13'h0123; l0_m[5] = 13'h0123;
    tick;
    cwr = 0; crd = 1; caddr_rd = 5;
    #1 chk("l0_rd5", cdata_rd, 13'h0123);
    csel = 1;
    #1 chk("l1_rd5", cdata_rd, l1_m[5]);
    csel = 0; cwr = 1; caddr_wr = 7; cdata_wr = ~l0_m[7]; caddr_rd = 7;
    #1 chk("rdw_old", cdata_rd, l0_m[7]);
    tick;
    l0_m[7] = cdata_wr; cwr = 0;
    #1 chk("rdw_new", cdata_rd, l0_m[7]);
    crd = 0;
    #1 chk("crd_off", cdata_rd, 0);

    for (int j = 0; j < 40; j++) begin
      csel = 1'($urandom);
      w = csel ? $urandom % 1024 : $urandom % 4096;
      r = csel ? $urandom % 1024 : $urandom % 4096;
      cwr = 1'($urandom); crd = 1; caddr_wr = w[11:0]; caddr_rd = r[11:0];
      cdata_wr = 13'($urandom);
      #1 chk("rnd_rd", cdata_rd, csel ? l1_m[r] : l0_m[r]);
      tick;
      if (cwr) begin
        if (csel) l1_m[w] = cdata_wr;
        else      l0_m[w] = cdata_wr;
      end
    end
    cwr = 0; crd = 0;
    chk("oob_clear", err_oob, 0);

    // Out-of-range L1 write must be dropped and flag err_oob.
    csel = 1; cwr = 1; caddr_wr = 1024; cdata_wr = ~l1_m[0];
    tick;
    cwr = 0;
    chk("oob_wr_flag", err_oob, 1);
    crd = 1; caddr_rd = 0;
    #1 chk("oob_wr_l1_0", cdata_rd, l1_m[0]);
    caddr_rd = 2000;
    #1 chk("oob_rd_zero", cdata_rd, 0);
    crd = 0; csel = 0;
    tick;
    chk("oob_sticky", err_oob, 1);

    // Readout with random backpressure.
    busy = 0; out_ready = 0;
    tick;
    k = 0; cyc = 0;
    while (k < 5120 && cyc < 20000) begin
      sel_e = (k >= 4096);
      chk("dump_valid", out_valid, 1);
      chk("dump_sel", out_sel, sel_e);
      chk("dump_addr", out_addr, sel_e ? k - 4096 : k);
      chk("dump_data", out_data, sel_e ? l1_m[k - 4096] : l0_m[k]);
      chk("dump_done", done, 0);
      out_ready = (cyc < 2) ? 1'b0 : 1'($urandom);
      tick;
      if (out_ready) k++;
      cyc++;
    end
    out_ready = 0;
    chk("dump_count", k, 5120);
    chk("fin_valid", out_valid, 0);
    chk("fin_done", done, 1);

    // Restart from FIN and let the watchdog expire.
    start = 1; tick; start = 0;
    chk("rearm_done", done, 0);
    chk("rearm_ready", ready, 1);
    repeat (TO - 1) tick;
    chk("wd_early_tmo", err_timeout, 0);
    chk("wd_early_ready", ready, 1);
    tick;
    chk("wd_tmo", err_timeout, 1);
    chk("wd_ready", ready, 0);
    chk("wd_done", done, 1);
    for (int j = 0; j < 4; j++) begin
      a = $urandom % 4096;
      iaddr = a[11:0]; #1 chk("img_kept", idata, img_m[a]);
    end

    // Reset in the middle of a readout.
    start = 1; tick; start = 0;
    busy = 1; tick; busy = 0; tick;
    out_ready = 1; repeat (10) tick; out_ready = 0;
    chk("mid_addr", out_addr, 10);
    chk("mid_data", out_data, l0_m[10]);
    reset = 0;
    cwr = 1; csel = 0; caddr_wr = 100; cdata_wr = ~l0_m[100]; l0_m[100] = cdata_wr;
    tick;
    cwr = 0;
    chk_reset_outs("mid_rst");
    reset = 1; tick;
    crd = 1; csel = 0;
    caddr_rd = 100;  #1 chk("post_rst_l0_100", cdata_rd, l0_m[100]);
    caddr_rd = 0;    #1 chk("post_rst_l0_0", cdata_rd, l0_m[0]);
    caddr_rd = 4095; #1 chk("post_rst_l0_4095", cdata_rd, l0_m[4095]);
    for (int j = 0; j < 5; j++) begin
      a = $urandom % 4096;
      caddr_rd = a[11:0]; #1 chk("post_rst_l0_rnd", cdata_rd, l0_m[a]);
    end
    csel = 1; caddr_rd = 1500;
    #1 chk("oob_rd2_zero", cdata_rd, 0);
    tick;
    chk("oob_rd_flag", err_oob, 1);
    crd = 0; csel = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
